// File: rtl/temp_monitor_s5_if.sv
// Signal bundle between the temperature monitor and its ADC/host side.
// master drives the ADC result and min/max re-arm; slave is the monitor itself.
interface temp_monitor_s5_if;
    logic       clr_minmax;
    logic [7:0] adc_code;
    logic       adc_done;
    logic       adc_clk;
    logic       adc_ce;
    logic       adc_clr;
    logic [7:0] degrees_c;
    logic [7:0] degrees_f;
    logic       sample_valid;
    logic       temp_alarm;
    logic [7:0] min_c;
    logic [7:0] max_c;
    logic [7:0] err_cnt;

    modport master (
        output clr_minmax, adc_code, adc_done,
        input  adc_clk, adc_ce, adc_clr, degrees_c, degrees_f, sample_valid,
        input  temp_alarm, min_c, max_c, err_cnt
    );

    modport slave (
        input  clr_minmax, adc_code, adc_done,
        output adc_clk, adc_ce, adc_clr, degrees_c, degrees_f, sample_valid,
        output temp_alarm, min_c, max_c, err_cnt
    );
endinterface

// File: rtl/temp_monitor_s5.sv
// Sense-diode temperature monitor: paces a slow ADC, averages valid codes,
// converts to Celsius/Fahrenheit, and tracks alarm, min/max and sample errors.
//
// state     | meaning
// S_COLLECT | accumulating samples, outputs hold
// S_PUBLISH | average ready in avg_q, outputs update this cycle
module temp_monitor_s5 #(
    parameter int DIV_LOG2   = 11,
    parameter int SCHED_LOG2 = 8,
    parameter int AVG_LOG2   = 2,
    parameter int OFFSET     = 133,
    parameter int HI_THRESH  = 85,
    parameter int HYST       = 5
) (
    input  logic              clk,
    input  logic              arst_n,
    temp_monitor_s5_if.slave  bus
);
    localparam int DIV_W   = DIV_LOG2 + 1;
    localparam int SLOT_W  = SCHED_LOG2;
    localparam int ACC_W   = 8 + AVG_LOG2;
    localparam int CNT_W   = AVG_LOG2 + 1;

    localparam logic [DIV_W-1:0]  DIV_TICK = DIV_W'((1 << DIV_LOG2) - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]        OFFSET_B = 8'(OFFSET);
    localparam logic signed [9:0] SET_TH   = 10'(HI_THRESH);
    localparam logic signed [9:0] CLR_TH   = 10'(HI_THRESH - HYST);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_PUBLISH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              adc_clr_q, adc_clr_d;
    logic [1:0]        ctl_q, ctl_d;          // {adc_ce, clr_inv}
    logic [7:0]        code_s1_q, code_s2_q;
    logic              done_s1_q, done_s2_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        avg_q, avg_d;
    logic [7:0]        degc_q, degc_d;
    logic [7:0]        degf_q, degf_d;
    logic              valid_q, valid_d;
    logic              alarm_q, alarm_d;
    logic [7:0]        min_q, min_d;
    logic [7:0]        max_q, max_d;
    logic              armed_q, armed_d;
    logic [7:0]        err_q, err_d;

    logic              tick;
    logic              samp_pt;
    logic              samp_ok;
    logic [ACC_W-1:0]  acc_sum;
    logic [7:0]        new_c;
    logic [7:0]        new_f;
    logic signed [9:0] new_c_s;

    assign tick    = (div_q == DIV_TICK);
    assign samp_pt = tick && (slot_q == '1);
    assign samp_ok = done_s2_q && (code_s2_q != 8'hFF);
    assign acc_sum = acc_q + ACC_W'(code_s2_q);
    assign new_c   = avg_q - OFFSET_B;
    // F = 2c - c/4 + c/16 + 32 on the raw byte, wrapping
    assign new_f   = {new_c[6:0], 1'b0} - (new_c >> 2) + (new_c >> 4) + 8'd32;
    assign new_c_s = signed'({{2{new_c[7]}}, new_c});

    always_comb begin
        state_d   = state_q;
        div_d     = div_q + DIV_W'(1);
        slot_d    = slot_q;
        adc_clr_d = adc_clr_q;
        ctl_d     = ctl_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        degc_d    = degc_q;
        degf_d    = degf_q;
        valid_d   = 1'b0;
        alarm_d   = alarm_q;
        min_d     = min_q;
        max_d     = max_q;
        armed_d   = armed_q;
        err_d     = err_q;

        if (tick) begin
            slot_d    = slot_q + SLOT_W'(1);
            adc_clr_d = (slot_q == SLOT_W'(1)) ^ ctl_q[0];
        end

        case (state_q)
            S_PUBLISH: begin
                state_d = S_COLLECT;
                degc_d  = new_c;
                degf_d  = new_f;
                valid_d = 1'b1;
                if (new_c_s >= SET_TH) begin
                    alarm_d = 1'b1;
                end else if (new_c_s < CLR_TH) begin
                    alarm_d = 1'b0;
                end
                // a re-arm coinciding with an update restarts tracking from this value
                if (!armed_q || bus.clr_minmax) begin
                    min_d = new_c;
                    max_d = new_c;
                end else begin
                    if ($signed(new_c) < $signed(min_q)) min_d = new_c;
                    if ($signed(new_c) > $signed(max_q)) max_d = new_c;
                end
                armed_d = 1'b1;
            end
            default: begin
                if (bus.clr_minmax) armed_d = 1'b0;
            end
        endcase

        if (samp_pt) begin
            if (samp_ok) begin
                if (cnt_q == CNT_LAST) begin
                    avg_d   = 8'(acc_sum >> AVG_LOG2);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_PUBLISH;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                // failed conversion: hunt the next enable/clear polarity, drop partial average
                err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                ctl_d = ctl_q + 2'd1;
                acc_d = '0;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_COLLECT;
            div_q     <= '0;
            slot_q    <= '0;
            adc_clr_q <= 1'b0;
            ctl_q     <= 2'b00;
            code_s1_q <= 8'h00;
            code_s2_q <= 8'h00;
            done_s1_q <= 1'b0;
            done_s2_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            avg_q     <= 8'h00;
            degc_q    <= 8'h00;
            degf_q    <= 8'h00;
            valid_q   <= 1'b0;
            alarm_q   <= 1'b0;
            min_q     <= 8'h7F;
            max_q     <= 8'h80;
            armed_q   <= 1'b0;
            err_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            slot_q    <= slot_d;
            adc_clr_q <= adc_clr_d;
            ctl_q     <= ctl_d;
            code_s1_q <= bus.adc_code;
            code_s2_q <= code_s1_q;
            done_s1_q <= bus.adc_done;
            done_s2_q <= done_s1_q;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            avg_q     <= avg_d;
            degc_q    <= degc_d;
            degf_q    <= degf_d;
            valid_q   <= valid_d;
            alarm_q   <= alarm_d;
            min_q     <= min_d;
            max_q     <= max_d;
            armed_q   <= armed_d;
            err_q     <= err_d;
        end
    end

    assign bus.adc_clk      = div_q[DIV_W-1];
    assign bus.adc_ce       = ctl_q[1];
    assign bus.adc_clr      = adc_clr_q;
    assign bus.degrees_c    = degc_q;
    assign bus.degrees_f    = degf_q;
    assign bus.sample_valid = valid_q;
    assign bus.temp_alarm   = alarm_q;
    assign bus.min_c        = min_q;
    assign bus.max_c        = max_q;
    assign bus.err_cnt      = err_q;
endmodule

// File: doc/temp_monitor_s5.md
TEMP_MONITOR_S5 -- requirements
Module: temp_monitor_s5

Interface
REQ-001 Parameter DIV_LOG2, default 11: clock-divider exponent; ADC clock period = 2^(DIV_LOG2+1) clk cycles.
REQ-002 Parameter SCHED_LOG2, default 8: slot-counter width; one conversion every 2^SCHED_LOG2 slots.
REQ-003 Parameter AVG_LOG2, default 2: 2^AVG_LOG2 valid samples are averaged per output update.
REQ-004 Parameter OFFSET, default 133: raw-code to Celsius offset.
REQ-005 Parameter HI_THRESH, default 85: alarm set threshold, signed Celsius.
REQ-006 Parameter HYST, default 5: alarm clear hysteresis, Celsius.
REQ-007 clk  input  1  system clock, ~50-100 MHz; all state on its rising edge.
REQ-008 arst_n  input  1  reset, asynchronous and active-low.
REQ-009 clr_minmax  input  1  one-cycle pulse; re-arms min/max tracking.
REQ-010 adc_code  input  8  sense-diode ADC result, quasi-static.
REQ-011 adc_done  input  1  ADC conversion-complete flag.
REQ-012 adc_clk  output  1  divided ADC clock (divider MSB).
REQ-013 adc_ce  output  1  ADC enable, polarity-hunted.
REQ-014 adc_clr  output  1  ADC conversion start/clear.
REQ-015 degrees_c  output  8  averaged temperature, signed two's-complement Celsius.
REQ-016 degrees_f  output  8  Fahrenheit of degrees_c, 8-bit wrap.
REQ-017 sample_valid  output  1  one-cycle pulse on each degrees_c/degrees_f update.
REQ-018 temp_alarm  output  1  over-temperature flag with hysteresis.
REQ-019 min_c, max_c  output  8 each  signed min/max of degrees_c since arm.
REQ-020 err_cnt  output  8  count of failed samples, saturating.

Function
REQ-021 Divider: (DIV_LOG2+1)-bit free-running counter; adc_clk = MSB; tick = cycle the counter equals {0, all ones}.
REQ-022 Slot counter (SCHED_LOG2 bits) SHALL increment on tick, wrapping to 0.
REQ-023 adc_clr SHALL be registered on tick as (slot==1) XOR clr_inv.
REQ-024 adc_code and adc_done SHALL pass a 2-flop synchronizer in clk before use.
REQ-025 Sample point: tick with slot all-ones; sample valid iff synced adc_done=1 and synced adc_code!=8'hFF.
REQ-026 Valid sample: add code to (8+AVG_LOG2)-bit accumulator, increment sample count.
REQ-027 When the count reaches 2^AVG_LOG2: avg = acc>>AVG_LOG2; next cycle degrees_c = avg-OFFSET (8-bit wrap), degrees_f from new degrees_c, sample_valid=1; accumulator and count cleared.
REQ-028 degrees_f = 2c - (c>>2) + (c>>4) + 32, logical shifts on the 8-bit pattern, mod 256.
REQ-029 Invalid sample: err_cnt +1 saturating at 255; {adc_ce,clr_inv} incremented as a 2-bit value (wraps 11->00); accumulator and count cleared; outputs hold.
REQ-030 On each update: temp_alarm set if degrees_c >= HI_THRESH (signed), cleared if < HI_THRESH-HYST, else held.
REQ-031 On each update: first update after arm loads min_c=max_c=new value; later updates apply signed min/max.
REQ-032 clr_minmax disarms tracking, min_c/max_c hold until next update; clr_minmax coincident with an update: update loads both with the new value.
REQ-033 Latency: sample point to sample_valid = 2 clk cycles when the sample completes an average.

Reset
REQ-034 arst_n low SHALL immediately clear divider, slot, synchronizers, accumulator, count, err_cnt, adc_ce, clr_inv, adc_clr, degrees_c, degrees_f, sample_valid, temp_alarm, and tracking-armed flag.
REQ-035 Reset values: min_c=8'h7F, max_c=8'h80; all other outputs 0; mid-conversion reset discards the partial average.

Verification (DIV_LOG2=2, SCHED_LOG2=3, AVG_LOG2=1: tick every 8 clks, sample every 64 clks)
REQ-036 Reset asserted mid-run -> all outputs at REQ-035 values same cycle; err_cnt=0, adc_ce=0.
REQ-037 adc_done=1, adc_code=158 two samples -> degrees_c=25, degrees_f=77, one sample_valid pulse.
REQ-038 Codes 160 then 162 -> degrees_c=28, degrees_f=82.
REQ-039 adc_done=0 at two sample points -> err_cnt=2, {adc_ce,clr_inv} 00->01->10, degrees_c unchanged, no sample_valid.
REQ-040 Averages 85, 81, 80, 79 -> temp_alarm 1,1,1,0.
REQ-041 Averages -10 (code 123) then 30 -> min_c=8'hF6, max_c=8'h1E; clr_minmax, then 20 -> min_c=max_c=8'h14.
